// File: rtl/cdb_arbiter_if.sv
// Bundle between the execute-stage FUs and the CDB arbiter. It carries the
// per-FU completion requests, the squash request and the registered CDB
// broadcast. The arbiter connects through the slave modport. The execute
// stage and the CDB consumers connect through the master modport.
interface cdb_arbiter_if #(
   parameter int NUM_FU = 6,
   parameter int XLEN   = 32,
   parameter int TAG_W  = 5
);
   logic [NUM_FU-1:0]       fu_done;
   logic [NUM_FU*TAG_W-1:0] fu_rob_tag;
   logic [NUM_FU*XLEN-1:0]  fu_result;
   logic [NUM_FU-1:0]       fu_take_branch;
   logic                    squash_valid;
   logic [TAG_W-1:0]        squash_rob_tag;
   logic [NUM_FU-1:0]       fu_ack;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_rob_tag;
   logic [XLEN-1:0]         cdb_value;
   logic                    cdb_take_branch;
   logic [2:0]              cdb_fu_idx;

   modport slave (
      input  fu_done, fu_rob_tag, fu_result, fu_take_branch,
      input  squash_valid, squash_rob_tag,
      output fu_ack,
      output cdb_valid, cdb_rob_tag, cdb_value, cdb_take_branch, cdb_fu_idx
   );

   modport master (
      output fu_done, fu_rob_tag, fu_result, fu_take_branch,
      output squash_valid, squash_rob_tag,
      input  fu_ack,
      input  cdb_valid, cdb_rob_tag, cdb_value, cdb_take_branch, cdb_fu_idx
   );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter. Each cycle it picks at most one completed FU result with
// round-robin priority and acks that FU combinationally. It then registers
// the winner onto the common data bus. While a squash is active, only FUs
// whose ROB tag matches the squashing branch can win.
// Optional macro CDB_BRANCH_PRIORITY_EN: a taken-branch result, lowest index
// first, overrides round-robin order without moving the pointer.
module cdb_arbiter #(
   parameter int NUM_FU = 6,
   parameter int XLEN   = 32,
   parameter int TAG_W  = 5
) (
   input logic          clock,
   input logic          reset,
   cdb_arbiter_if.slave bus
);
   localparam int IDX_W = 3;

   logic [NUM_FU-1:0] cand;
   logic              rr_found;
   logic [IDX_W-1:0]  rr_idx;
   logic              br_found;
   logic [IDX_W-1:0]  br_idx;
   logic              grant;
   logic [IDX_W-1:0]  winner;
   logic [IDX_W-1:0]  rr_ptr;
   int                scan;

   logic              vld_p1;
   logic [TAG_W-1:0]  tag_p1;
   logic [XLEN-1:0]   value_p1;
   logic              take_branch_p1;
   logic [IDX_W-1:0]  fu_idx_p1;

   // Build the candidate set; a squash narrows it to the squashing branch's tag.
   always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (bus.fu_done[i]) begin
            if (!bus.squash_valid)
               cand[i] = 1'b1;
            else if (bus.fu_rob_tag[i*TAG_W +: TAG_W] == bus.squash_rob_tag)
               cand[i] = 1'b1;
         end
      end
   end

   // Round-robin scan starting at rr_ptr, wrapping explicitly past NUM_FU-1.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      scan     = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NUM_FU)
            scan = scan - NUM_FU;
         if (!rr_found && cand[scan]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(scan);
         end
      end
   end

`ifdef CDB_BRANCH_PRIORITY_EN
   // Lowest-index taken branch among the candidates overrides round-robin.
   always_comb begin
      br_found = 1'b0;
      br_idx   = '0;
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (cand[i] && bus.fu_take_branch[i]) begin
            br_found = 1'b1;
            br_idx   = IDX_W'(i);
         end
      end
   end
`else
   assign br_found = 1'b0;
   assign br_idx   = '0;
`endif

   // No grant is possible while reset is held low.
   assign grant  = reset && (br_found || rr_found);
   assign winner = br_found ? br_idx : rr_idx;

   // One-hot same-cycle ack to the winning FU.
   always_comb begin
      bus.fu_ack = '0;
      if (grant)
         bus.fu_ack[winner] = 1'b1;
   end

   // Stage p1: register the winner onto the CDB and advance the pointer.
   always_ff @(posedge clock) begin
      if (!reset) begin
         vld_p1         <= 1'b0;
         tag_p1         <= '0;
         value_p1       <= '0;
         take_branch_p1 <= 1'b0;
         fu_idx_p1      <= '0;
         rr_ptr         <= '0;
      end else begin
         vld_p1 <= grant;
         if (grant) begin
            tag_p1         <= bus.fu_rob_tag[int'(winner)*TAG_W +: TAG_W];
            value_p1       <= bus.fu_result[int'(winner)*XLEN +: XLEN];
            take_branch_p1 <= bus.fu_take_branch[winner];
            fu_idx_p1      <= winner;
         end
         if (grant && !br_found)
            rr_ptr <= (winner == IDX_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
      end
   end

   assign bus.cdb_valid       = vld_p1;
   assign bus.cdb_rob_tag     = tag_p1;
   assign bus.cdb_value       = value_p1;
   assign bus.cdb_take_branch = take_branch_p1;
   assign bus.cdb_fu_idx      = fu_idx_p1;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter. It runs a table of directed vectors and then
// randomized FU traffic that follows the hold-until-ack handshake. Every
// cycle is compared against a reference model computed from the arbitration
// rules.
module tb_cdb_arbiter;
   localparam int NUM_FU = 6;
   localparam int XLEN   = 32;
   localparam int TAG_W  = 5;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;

   cdb_arbiter_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference model state
   int              m_ptr;
   logic            m_valid;
   logic [4:0]      m_tag;
   logic [31:0]     m_val;
   logic            m_tb;
   logic [2:0]      m_idx;
   logic [5:0]      last_ack;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Winner by the arbitration rules; -1 when there is no grant.
   function automatic int model_win(input logic [5:0] done, input logic [29:0] tags,
                                    input logic [5:0] tbr, input logic sv,
                                    input logic [4:0] stag, input int ptr,
                                    output bit by_branch);
      bit ok [NUM_FU];
      by_branch = 1'b0;
      for (int i = 0; i < NUM_FU; i++)
         ok[i] = done[i] && (!sv || (tags[i*TAG_W +: TAG_W] == stag));
`ifdef CDB_BRANCH_PRIORITY_EN
      for (int i = 0; i < NUM_FU; i++)
         if (ok[i] && tbr[i]) begin
            by_branch = 1'b1;
            return i;
         end
`endif
      for (int k = 0; k < NUM_FU; k++)
         if (ok[(ptr + k) % NUM_FU]) return (ptr + k) % NUM_FU;
      return -1;
   endfunction

   task automatic do_cycle(input logic r, input logic [5:0] done, input logic [29:0] tags,
                           input logic [191:0] res, input logic [5:0] tbr,
                           input logic sv, input logic [4:0] stag);
      int         w;
      bit         br;
      logic [5:0] exp_ack;
      reset              = r;
      bus.fu_done        = done;
      bus.fu_rob_tag     = tags;
      bus.fu_result      = res;
      bus.fu_take_branch = tbr;
      bus.squash_valid   = sv;
      bus.squash_rob_tag = stag;
      #1;
      w = model_win(done, tags, tbr, sv, stag, m_ptr, br);
      if (!r) w = -1;
      exp_ack = (w >= 0) ? 6'(1 << w) : 6'd0;
      last_ack = bus.fu_ack;
      chk("fu_ack", 64'(bus.fu_ack), 64'(exp_ack));
      @(posedge clock);
      if (!r) begin
         m_valid = 0; m_tag = 0; m_val = 0; m_tb = 0; m_idx = 0; m_ptr = 0;
      end else if (w >= 0) begin
         m_valid = 1;
         m_tag   = tags[w*TAG_W +: TAG_W];
         m_val   = res[w*XLEN +: XLEN];
         m_tb    = tbr[w];
         m_idx   = 3'(w);
         if (!br) m_ptr = (w + 1) % NUM_FU;
      end else begin
         m_valid = 0;
      end
      #1;
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      chk("cdb_rob_tag", 64'(bus.cdb_rob_tag), 64'(m_tag));
      chk("cdb_value", 64'(bus.cdb_value), 64'(m_val));
      chk("cdb_take_branch", 64'(bus.cdb_take_branch), 64'(m_tb));
      chk("cdb_fu_idx", 64'(bus.cdb_fu_idx), 64'(m_idx));
      chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
   endtask

   typedef struct {
      logic       r;
      logic [5:0] done;
      int         ov_fu;
      logic [4:0] ov_tag;
      logic [5:0] tbr;
      logic       sv;
      logic [4:0] stag;
      logic [5:0] exp_ack;
      logic       exp_valid;
      logic [4:0] exp_tag;
      logic [2:0] exp_ptr;
   } vec_t;

   vec_t vecs [$];

   function automatic logic [29:0] mk_tags(input int ov_fu, input logic [4:0] ov_tag);
      logic [29:0] t;
      for (int i = 0; i < NUM_FU; i++) t[i*TAG_W +: TAG_W] = 5'(16 + i);
      if (ov_fu >= 0) t[ov_fu*TAG_W +: TAG_W] = ov_tag;
      return t;
   endfunction

   function automatic logic [191:0] mk_res();
      logic [191:0] v;
      for (int i = 0; i < NUM_FU; i++) v[i*XLEN +: XLEN] = 32'h1000 + 32'(i);
      v[31:0] = 32'hDEAD;
      return v;
   endfunction

   logic [5:0]  r_done;
   logic [29:0] r_tags;
   logic [191:0] r_res;
   logic [5:0]  r_tbr;

   initial begin
      n_tests = 0; n_fail = 0;
      m_ptr = 0; m_valid = 0; m_tag = 0; m_val = 0; m_tb = 0; m_idx = 0;
      last_ack = 0;
      reset = 0;
      bus.fu_done = 0; bus.fu_rob_tag = 0; bus.fu_result = 0;
      bus.fu_take_branch = 0; bus.squash_valid = 0; bus.squash_rob_tag = 0;
      @(posedge clock); #1;

      //             r  done        ovfu ovtag tbr        sv stag ack        vld tag   ptr
      vecs.push_back('{0, 6'b000000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000000, 0, 5'd0,  3'd0});
      vecs.push_back('{0, 6'b000000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000000, 0, 5'd0,  3'd0});
      vecs.push_back('{1, 6'b000001,  0, 5'd3, 6'b000000, 0, 5'd0, 6'b000001, 1, 5'd3,  3'd1});
      vecs.push_back('{0, 6'b000000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000000, 0, 5'd0,  3'd0});
      vecs.push_back('{1, 6'b111111, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000001, 1, 5'd16, 3'd1});
      vecs.push_back('{1, 6'b111110, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000010, 1, 5'd17, 3'd2});
      vecs.push_back('{1, 6'b111100, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000100, 1, 5'd18, 3'd3});
      vecs.push_back('{1, 6'b111000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b001000, 1, 5'd19, 3'd4});
      vecs.push_back('{1, 6'b110000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b010000, 1, 5'd20, 3'd5});
      vecs.push_back('{1, 6'b100000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b100000, 1, 5'd21, 3'd0});
      vecs.push_back('{1, 6'b000000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000000, 0, 5'd21, 3'd0});
      vecs.push_back('{1, 6'b010000, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b010000, 1, 5'd20, 3'd5});
      vecs.push_back('{1, 6'b100001, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b100000, 1, 5'd21, 3'd0});
      vecs.push_back('{1, 6'b000001, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000001, 1, 5'd16, 3'd1});
      vecs.push_back('{1, 6'b000100, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000100, 1, 5'd18, 3'd3});
      vecs.push_back('{1, 6'b010010,  1, 5'd7, 6'b000000, 1, 5'd7, 6'b000010, 1, 5'd7,  3'd2});
      vecs.push_back('{1, 6'b010010,  1, 5'd6, 6'b000000, 1, 5'd7, 6'b000000, 0, 5'd7,  3'd2});
`ifdef CDB_BRANCH_PRIORITY_EN
      vecs.push_back('{1, 6'b000110, -1, 5'd0, 6'b000010, 0, 5'd0, 6'b000010, 1, 5'd17, 3'd2});
`else
      vecs.push_back('{1, 6'b000110, -1, 5'd0, 6'b000010, 0, 5'd0, 6'b000100, 1, 5'd18, 3'd3});
`endif
      vecs.push_back('{0, 6'b000100, -1, 5'd0, 6'b000000, 0, 5'd0, 6'b000000, 0, 5'd0,  3'd0});

      for (int v = 0; v < vecs.size(); v++) begin
         do_cycle(vecs[v].r, vecs[v].done, mk_tags(vecs[v].ov_fu, vecs[v].ov_tag), mk_res(),
                  vecs[v].tbr, vecs[v].sv, vecs[v].stag);
         chk($sformatf("vec%0d.ack", v), 64'(last_ack), 64'(vecs[v].exp_ack));
         chk($sformatf("vec%0d.valid", v), 64'(bus.cdb_valid), 64'(vecs[v].exp_valid));
         chk($sformatf("vec%0d.ptr", v), 64'(dut.rr_ptr), 64'(vecs[v].exp_ptr));
         if (vecs[v].exp_valid)
            chk($sformatf("vec%0d.tag", v), 64'(bus.cdb_rob_tag), 64'(vecs[v].exp_tag));
      end

      // randomized FU traffic honoring hold-until-ack
      r_done = 0; r_tags = 0; r_res = 0; r_tbr = 0;
      for (int c = 0; c < 600; c++) begin
         logic       sv;
         logic [4:0] stag;
         logic       r;
         for (int i = 0; i < NUM_FU; i++) begin
            if (!r_done[i] && ($urandom_range(0, 1) == 1)) begin
               r_done[i] = 1'b1;
               r_tags[i*TAG_W +: TAG_W] = 5'($urandom_range(0, 31));
               r_res[i*XLEN +: XLEN]    = $urandom;
               r_tbr[i]                 = ($urandom_range(0, 3) == 0);
            end
         end
         sv   = ($urandom_range(0, 7) == 0);
         stag = r_tags[$urandom_range(0, NUM_FU - 1)*TAG_W +: TAG_W];
         if ($urandom_range(0, 3) == 0) stag = 5'($urandom_range(0, 31));
         r    = ($urandom_range(0, 49) != 0);
         do_cycle(r, r_done, r_tags, r_res, r_tbr, sv, stag);
         r_done = r_done & ~last_ack;
         if (sv) r_done = 6'b000000;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
